// File: rtl/trip_loop_predictor_pkg.sv
// Shared types for the trip-count loop predictor: core config, entry layout
// and the table geometry the entry fields are sized from.
package trip_loop_predictor_pkg;

  typedef struct packed {
    logic loop_enable;
  } cfg_t;

  localparam cfg_t DEFAULT_CFG = '{loop_enable: 1'b1};

  localparam int unsigned LP_ENTRIES   = 64;
  localparam int unsigned LP_TAG_BITS  = 10;
  localparam int unsigned LP_CNT_BITS  = 10;
  localparam int unsigned LP_CONF_BITS = 2;
  localparam int unsigned LP_AGE_BITS  = 2;
  localparam int unsigned LP_IDX_BITS  = $clog2(LP_ENTRIES);

  typedef struct packed {
    logic                    valid;
    logic [LP_TAG_BITS-1:0]  tag;
    logic [LP_CNT_BITS-1:0]  trip;
    logic [LP_CNT_BITS-1:0]  c_iter;
    logic [LP_CNT_BITS-1:0]  s_iter;
    logic [LP_CONF_BITS-1:0] conf;
    logic [LP_AGE_BITS-1:0]  age;
  } loop_entry_t;

  // Instructions are 4 bytes, so fetch slot n sits 4*n past the base.
  function automatic logic [31:0] slot_pc(input logic [31:0] base, input int unsigned slot);
    return base + 32'(slot << 2);
  endfunction

endpackage

// File: rtl/trip_loop_predictor_if.sv
// Predict / speculative-advance / commit signal bundle of the loop predictor.
interface trip_loop_predictor_if #(
  parameter int unsigned INSTR_PER_FETCH = 4
);
  logic                       predict_valid_i;
  logic [31:0]                predict_base_pc_i;
  logic                       predict_valid_o;
  logic [INSTR_PER_FETCH-1:0] predict_hit_o;
  logic [INSTR_PER_FETCH-1:0] predict_taken_o;
  logic [INSTR_PER_FETCH-1:0] predict_confident_o;

  logic                       spec_adv_valid_i;
  logic [31:0]                spec_adv_pc_i;
  logic                       flush_i;

  logic                       update_valid_i;
  logic [31:0]                update_pc_i;
  logic                       update_is_cond_i;
  logic                       update_taken_i;

  modport master (
    output predict_valid_i, predict_base_pc_i,
    input  predict_valid_o, predict_hit_o, predict_taken_o, predict_confident_o,
    output spec_adv_valid_i, spec_adv_pc_i, flush_i,
    output update_valid_i, update_pc_i, update_is_cond_i, update_taken_i
  );

  modport slave (
    input  predict_valid_i, predict_base_pc_i,
    output predict_valid_o, predict_hit_o, predict_taken_o, predict_confident_o,
    input  spec_adv_valid_i, spec_adv_pc_i, flush_i,
    input  update_valid_i, update_pc_i, update_is_cond_i, update_taken_i
  );
endinterface

// File: rtl/trip_loop_predictor_entry_update.sv
// Next-state of one loop entry from the commit update, speculative advance and flush
// that target it in the same cycle.
module loop_entry_update
  import trip_loop_predictor_pkg::*;
#(
  parameter int unsigned TAG_BITS  = LP_TAG_BITS,
  parameter int unsigned CNT_BITS  = LP_CNT_BITS,
  parameter int unsigned CONF_BITS = LP_CONF_BITS,
  parameter int unsigned AGE_BITS  = LP_AGE_BITS
) (
  input  loop_entry_t         cur,
  input  logic                upd_sel,
  input  logic [TAG_BITS-1:0] upd_tag,
  input  logic                upd_taken,
  input  logic                spec_sel,
  input  logic [TAG_BITS-1:0] spec_tag,
  input  logic                flush,
  output loop_entry_t         nxt
);
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [AGE_BITS-1:0]  AGE_MAX  = '1;

  logic                 upd_hit;
  logic                 spec_hit;
  logic [CNT_BITS-1:0]  c_inc;
  logic [CNT_BITS-1:0]  s_inc;
  logic [CONF_BITS-1:0] conf_inc;

  assign upd_hit  = cur.valid && (cur.tag == upd_tag);
  assign spec_hit = cur.valid && (cur.tag == spec_tag);
  assign c_inc    = cur.c_iter + 1'b1;
  assign s_inc    = cur.s_iter + 1'b1;
  assign conf_inc = cur.conf + 1'b1;

  always_comb begin
    nxt = cur;

    // Flush resynchronises the speculative count to the committed one and beats an advance.
    if (flush) begin
      nxt.s_iter = cur.c_iter;
    end else if (spec_sel && spec_hit) begin
      nxt.s_iter = (s_inc == cur.trip) ? '0 : s_inc;
    end

    if (upd_sel) begin
      if (upd_hit && upd_taken) begin
        if (&cur.c_iter) begin
          // Counter overflow: the loop is too long to track, forget it.
          nxt.c_iter = '0;
          nxt.trip   = '0;
          nxt.conf   = '0;
        end else begin
          nxt.c_iter = c_inc;
        end
      end else if (upd_hit) begin
        if (cur.trip == c_inc) begin
          if (cur.conf != CONF_MAX) begin
            nxt.conf = conf_inc;
            if (conf_inc == CONF_MAX) nxt.age = AGE_MAX;
          end
        end else begin
          nxt.trip = c_inc;
          nxt.conf = '0;
        end
        nxt.c_iter = '0;
      end else if (upd_taken) begin
        if (!cur.valid || (cur.age == '0)) begin
          nxt.valid  = 1'b1;
          nxt.tag    = upd_tag;
          nxt.trip   = '0;
          nxt.conf   = '0;
          nxt.c_iter = CNT_BITS'(1);
          nxt.s_iter = CNT_BITS'(1);
          nxt.age    = AGE_MAX;
        end else begin
          nxt.age = cur.age - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/trip_loop_predictor.sv
// Direct-mapped trip-count loop predictor: one-cycle registered per-slot lookup,
// speculative iteration tracking with flush recovery, and commit-time training.
module trip_loop_predictor
  import trip_loop_predictor_pkg::*;
#(
  parameter cfg_t        Cfg             = DEFAULT_CFG,
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned ENTRIES         = LP_ENTRIES,
  parameter int unsigned TAG_BITS        = LP_TAG_BITS,
  parameter int unsigned CNT_BITS        = LP_CNT_BITS,
  parameter int unsigned CONF_BITS       = LP_CONF_BITS,
  parameter int unsigned CONF_THRESH     = 2,
  parameter int unsigned AGE_BITS        = LP_AGE_BITS
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  trip_loop_predictor_if.slave bus
);
  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned PC_HI    = 2 + IDX_BITS + TAG_BITS;

  loop_entry_t entry_reg  [ENTRIES];
  loop_entry_t entry_next [ENTRIES];

  logic                       update_fire;
  logic [IDX_BITS-1:0]        upd_idx;
  logic [IDX_BITS-1:0]        spec_idx;
  logic [TAG_BITS-1:0]        upd_tag;
  logic [TAG_BITS-1:0]        spec_tag;
  logic                       unused_pc_bits;

  logic [INSTR_PER_FETCH-1:0] hit_next;
  logic [INSTR_PER_FETCH-1:0] taken_next;
  logic [INSTR_PER_FETCH-1:0] conf_next;
  logic                       pred_valid_reg;
  logic [INSTR_PER_FETCH-1:0] hit_reg;
  logic [INSTR_PER_FETCH-1:0] taken_reg;
  logic [INSTR_PER_FETCH-1:0] conf_reg;

  assign update_fire = bus.update_valid_i && bus.update_is_cond_i;
  assign upd_idx     = bus.update_pc_i[2 +: IDX_BITS];
  assign upd_tag     = bus.update_pc_i[2 + IDX_BITS +: TAG_BITS];
  assign spec_idx    = bus.spec_adv_pc_i[2 +: IDX_BITS];
  assign spec_tag    = bus.spec_adv_pc_i[2 + IDX_BITS +: TAG_BITS];

  assign unused_pc_bits = ^{bus.update_pc_i[31:PC_HI], bus.update_pc_i[1:0],
                            bus.spec_adv_pc_i[31:PC_HI], bus.spec_adv_pc_i[1:0]};

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    loop_entry_update #(
      .TAG_BITS (TAG_BITS),
      .CNT_BITS (CNT_BITS),
      .CONF_BITS(CONF_BITS),
      .AGE_BITS (AGE_BITS)
    ) u_update (
      .cur      (entry_reg[gi]),
      .upd_sel  (update_fire && (upd_idx == IDX_BITS'(gi))),
      .upd_tag  (upd_tag),
      .upd_taken(bus.update_taken_i),
      .spec_sel (bus.spec_adv_valid_i && (spec_idx == IDX_BITS'(gi))),
      .spec_tag (spec_tag),
      .flush    (bus.flush_i),
      .nxt      (entry_next[gi])
    );
  end

  // Flush touches every entry at once, so the table is kept in flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) entry_reg[i] <= '0;
    end else begin
      entry_reg <= entry_next;
    end
  end

  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
    logic [31:0]         pc;
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    loop_entry_t         e;
    logic [CNT_BITS-1:0] s_inc;
    logic                unused_slot_bits;

    assign pc    = slot_pc(bus.predict_base_pc_i, gi);
    assign idx   = pc[2 +: IDX_BITS];
    assign tag   = pc[2 + IDX_BITS +: TAG_BITS];
    assign e     = entry_reg[idx];
    assign s_inc = e.s_iter + 1'b1;
    assign unused_slot_bits = ^{pc[31:PC_HI], pc[1:0]};

    assign hit_next[gi]   = Cfg.loop_enable && e.valid && (e.tag == tag);
    // Predict not-taken only on the iteration that closes the learned trip.
    assign taken_next[gi] = hit_next[gi] && (s_inc != e.trip);
    assign conf_next[gi]  = hit_next[gi] && (e.conf >= CONF_BITS'(CONF_THRESH)) && (e.trip != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_reg <= 1'b0;
      hit_reg        <= '0;
      taken_reg      <= '0;
      conf_reg       <= '0;
    end else begin
      pred_valid_reg <= bus.predict_valid_i;
      hit_reg        <= bus.predict_valid_i ? hit_next   : '0;
      taken_reg      <= bus.predict_valid_i ? taken_next : '0;
      conf_reg       <= bus.predict_valid_i ? conf_next  : '0;
    end
  end

  assign bus.predict_valid_o     = pred_valid_reg;
  assign bus.predict_hit_o       = hit_reg;
  assign bus.predict_taken_o     = taken_reg;
  assign bus.predict_confident_o = conf_reg;

endmodule

// File: tb/tb_trip_loop_predictor.sv
// Directed bench for trip_loop_predictor: training, speculative advance/flush,
// retraining, replacement aging and asynchronous reset.
module tb_trip_loop_predictor;
  import trip_loop_predictor_pkg::*;

  localparam logic [31:0] PC_A = 32'h8000_0100;
  localparam logic [31:0] PC_B = 32'h8000_1100;
  localparam logic [31:0] PC_N = 32'h8000_2100;
  localparam logic [31:0] PC_C = 32'h8000_0208;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  trip_loop_predictor_if #(.INSTR_PER_FETCH(4)) bus ();

  trip_loop_predictor #(
    .Cfg            (DEFAULT_CFG),
    .INSTR_PER_FETCH(4),
    .ENTRIES        (64),
    .TAG_BITS       (10),
    .CNT_BITS       (10),
    .CONF_BITS      (2),
    .CONF_THRESH    (2),
    .AGE_BITS       (2)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [31:0] pc, input logic taken, input logic is_cond = 1'b1);
    bus.update_valid_i   = 1'b1;
    bus.update_is_cond_i = is_cond;
    bus.update_pc_i      = pc;
    bus.update_taken_i   = taken;
    @(posedge clk_i); #1;
    bus.update_valid_i   = 1'b0;
    bus.update_is_cond_i = 1'b0;
    $display("commit pc=%h taken=%b cond=%b", pc, taken, is_cond);
  endtask

  task automatic spec(input logic [31:0] pc, input logic adv, input logic fl);
    bus.spec_adv_valid_i = adv;
    bus.spec_adv_pc_i    = pc;
    bus.flush_i          = fl;
    @(posedge clk_i); #1;
    bus.spec_adv_valid_i = 1'b0;
    bus.flush_i          = 1'b0;
    $display("spec pc=%h adv=%b flush=%b", pc, adv, fl);
  endtask

  task automatic lookup(input logic [31:0] base, input logic [3:0] e_hit,
                        input logic [3:0] e_taken, input logic [3:0] e_conf, input string tag);
    bus.predict_valid_i   = 1'b1;
    bus.predict_base_pc_i = base;
    @(posedge clk_i); #1;
    bus.predict_valid_i   = 1'b0;
    $display("lookup %s base=%h valid=%b hit=%b taken=%b conf=%b", tag, base,
             bus.predict_valid_o, bus.predict_hit_o, bus.predict_taken_o, bus.predict_confident_o);
    check({tag, "/valid"}, 32'(bus.predict_valid_o), 32'd1);
    check({tag, "/hit"},   32'(bus.predict_hit_o), 32'(e_hit));
    check({tag, "/taken"}, 32'(bus.predict_taken_o), 32'(e_taken));
    check({tag, "/conf"},  32'(bus.predict_confident_o), 32'(e_conf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.predict_valid_i   = 1'b0;
    bus.predict_base_pc_i = '0;
    bus.spec_adv_valid_i  = 1'b0;
    bus.spec_adv_pc_i     = '0;
    bus.flush_i           = 1'b0;
    bus.update_valid_i    = 1'b0;
    bus.update_pc_i       = '0;
    bus.update_is_cond_i  = 1'b0;
    bus.update_taken_i    = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    $display("reset held: valid=%b hit=%b", bus.predict_valid_o, bus.predict_hit_o);
    check("reset/valid", 32'(bus.predict_valid_o), 32'd0);
    check("reset/hit", 32'(bus.predict_hit_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    $display("idle after release: valid=%b", bus.predict_valid_o);
    check("idle/valid", 32'(bus.predict_valid_o), 32'd0);

    lookup(PC_A, 4'b0000, 4'b0000, 4'b0000, "cold");

    // Three committed passes of a 4-iteration loop: TTT then exit.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) commit(PC_A, 1'b1);
      commit(PC_A, 1'b0);
    end
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0001, "trained");
    lookup(32'h8000_00F8, 4'b0100, 4'b0100, 4'b0100, "slot2");

    commit(PC_A, 1'b0, 1'b0);
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0001, "noncond_ignored");

    spec(PC_A, 1'b0, 1'b1);
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0001, "after_flush");
    for (int k = 0; k < 3; k++) spec(PC_A, 1'b1, 1'b0);
    lookup(PC_A, 4'b0001, 4'b0000, 4'b0001, "exit_pred");
    spec(PC_A, 1'b1, 1'b0);
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0001, "wrap");

    for (int k = 0; k < 2; k++) spec(PC_A, 1'b1, 1'b0);
    spec(PC_A, 1'b0, 1'b1);
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0001, "flush_restore");
    for (int k = 0; k < 3; k++) spec(PC_A, 1'b1, 1'b0);
    lookup(PC_A, 4'b0001, 4'b0000, 4'b0001, "flush_restore_exit");
    spec(PC_A, 1'b1, 1'b0);

    for (int k = 0; k < 2; k++) spec(PC_A, 1'b1, 1'b0);
    spec(PC_A, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) spec(PC_A, 1'b1, 1'b0);
    lookup(PC_A, 4'b0001, 4'b0000, 4'b0001, "flush_beats_adv");
    spec(PC_A, 1'b1, 1'b0);

    for (int k = 0; k < 5; k++) commit(PC_A, 1'b1);
    commit(PC_A, 1'b0);
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0000, "retrip6");

    for (int k = 0; k < 3; k++) begin
      commit(PC_B, 1'b1);
      lookup(PC_A, 4'b0001, 4'b0001, 4'b0000, "aging");
    end
    bus.update_valid_i   = 1'b1;
    bus.update_is_cond_i = 1'b1;
    bus.update_pc_i      = PC_B;
    bus.update_taken_i   = 1'b1;
    lookup(PC_A, 4'b0001, 4'b0001, 4'b0000, "no_bypass");
    bus.update_valid_i   = 1'b0;
    bus.update_is_cond_i = 1'b0;
    $display("commit pc=%h taken=1 cond=1 (with lookup)", PC_B);
    lookup(PC_A, 4'b0000, 4'b0000, 4'b0000, "evicted");
    lookup(PC_B, 4'b0001, 4'b0001, 4'b0000, "allocated");

    commit(PC_N, 1'b0);
    lookup(PC_B, 4'b0001, 4'b0001, 4'b0000, "nt_miss_ignored");

    commit(PC_C, 1'b1);
    commit(PC_C, 1'b1);
    commit(PC_C, 1'b1);
    commit(PC_C, 1'b0);
    commit(PC_C, 1'b1);
    lookup(PC_C, 4'b0001, 4'b0001, 4'b0000, "pre_reset");
    #2;
    rst_ni = 1'b0;
    #1;
    $display("async reset: valid=%b hit=%b taken=%b", bus.predict_valid_o, bus.predict_hit_o,
             bus.predict_taken_o);
    check("async_reset/valid", 32'(bus.predict_valid_o), 32'd0);
    check("async_reset/hit", 32'(bus.predict_hit_o), 32'd0);
    check("async_reset/taken", 32'(bus.predict_taken_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("post_reset/valid", 32'(bus.predict_valid_o), 32'd0);
    lookup(PC_C, 4'b0000, 4'b0000, 4'b0000, "post_reset_c");
    lookup(PC_B, 4'b0000, 4'b0000, 4'b0000, "post_reset_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
